// File: rtl/covid_pkg.sv
// Shared types for the covid launcher and the trajectory logic: slot and
// scheduler state encodings, LFSR feedback taps, and a small popcount helper.
package covid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIVE = 2'd1,
    DONE = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    WAIT_GAP  = 2'd0,
    PICK      = 2'd1,
    EXHAUSTED = 2'd2
  } sched_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Slot count is capped at 8, so an 8-bit popcount covers every configuration.
  function automatic logic [3:0] count_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/covid_lfsr.sv
// Free-running 16-bit Galois LFSR used to jitter the gap between covid drops.
// It advances on every clock, independent of the game pause.
module covid_lfsr
  import covid_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/covid_drop_scheduler.sv
// Enemy-side covid launcher: spaces drops by a jittered frame gap, holds
// dripStart for each live slot and retires slots on hit or lifetime expiry.
//
//   state     | meaning
//   WAIT_GAP  | counting frames down to the next drop
//   PICK      | one clock: launch lowest IDLE slot, reload the gap
//   EXHAUSTED | no IDLE slot left; stays here until reset
module covid_drop_scheduler
  import covid_pkg::*;
#(
  parameter int          NUM_SLOTS       = 4,
  parameter int          MIN_GAP_FRAMES  = 30,
  parameter int          GAP_RANGE_BITS  = 5,
  parameter int          MAX_LIFE_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic                               enable,
  input  logic [NUM_SLOTS-1:0]               slotHit,
  input  logic [NUM_SLOTS-1:0]               dripEnable,
  output logic [NUM_SLOTS-1:0]               dripStart,
  output logic [NUM_SLOTS-1:0]               covidDisapper,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     liveCount,
  output logic                               allDone
);

  localparam int CNT_W    = $clog2(NUM_SLOTS + 1);
  localparam int GAP_MAX  = MIN_GAP_FRAMES + (1 << GAP_RANGE_BITS);
  localparam int GAP_W    = $clog2(GAP_MAX + 1);
  localparam int LIFE_W   = $clog2(MAX_LIFE_FRAMES + 1);
  localparam logic [GAP_W-1:0]  GAP_RESET = GAP_W'((MIN_GAP_FRAMES < 1) ? 1 : MIN_GAP_FRAMES);
  localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(MAX_LIFE_FRAMES);
  localparam logic [15:0]       GAP_MASK  = 16'((32'd1 << GAP_RANGE_BITS) - 32'd1);

  sched_state_t         sched_q, sched_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [GAP_W-1:0]     gap_load;
  logic [31:0]          gap_sum;
  logic [15:0]          lfsr_w;
  logic                 frame_tick;
  logic [NUM_SLOTS-1:0] slot_idle, slot_live, slot_done;
  logic [NUM_SLOTS-1:0] pick_oh, launch_vec;
  logic                 idle_any;

  logic [NUM_SLOTS-1:0] drip_start_q;
  logic [NUM_SLOTS-1:0] covid_disapper_q;
  logic [CNT_W-1:0]     live_count_q;
  logic                 all_done_q;

  assign frame_tick = startOfFrame & enable;

  covid_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .lfsr_o (lfsr_w)
  );

  // A zero sum can only occur with MIN_GAP_FRAMES=0 and a zero draw; clamp to 1.
  assign gap_sum  = 32'(MIN_GAP_FRAMES) + {16'd0, lfsr_w & GAP_MASK};
  assign gap_load = (gap_sum == 32'd0) ? GAP_W'(1) : GAP_W'(gap_sum);

  always_comb begin
    pick_oh  = '0;
    idle_any = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!idle_any && slot_idle[i]) begin
        pick_oh[i] = 1'b1;
        idle_any   = 1'b1;
      end
    end
  end

  always_comb begin
    sched_d    = sched_q;
    gap_d      = gap_q;
    launch_vec = '0;
    case (sched_q)
      WAIT_GAP: begin
        if (frame_tick) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) sched_d = PICK;
        end
      end
      PICK: begin
        if (idle_any) begin
          launch_vec = pick_oh;
          gap_d      = gap_load;
          sched_d    = WAIT_GAP;
        end else begin
          sched_d = EXHAUSTED;
        end
      end
      EXHAUSTED: ;
      default: sched_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sched_q <= WAIT_GAP;
      gap_q   <= GAP_RESET;
    end else begin
      sched_q <= sched_d;
      gap_q   <= gap_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_state_t       slot_q, slot_d;
    logic [LIFE_W-1:0] life_q, life_d;
    logic              hit;

    assign hit = slotHit[i] & dripEnable[i];

    always_comb begin
      slot_d = slot_q;
      life_d = life_q;
      case (slot_q)
        IDLE: begin
          if (launch_vec[i]) begin
            slot_d = LIVE;
            life_d = LIFE_LOAD;
          end
        end
        LIVE: begin
          if (hit || (frame_tick && life_q == LIFE_W'(1))) begin
            slot_d = DONE;
            life_d = '0;
          end else if (frame_tick) begin
            life_d = life_q - LIFE_W'(1);
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        slot_q <= IDLE;
        life_q <= '0;
      end else begin
        slot_q <= slot_d;
        life_q <= life_d;
      end
    end

    assign slot_idle[i] = (slot_q == IDLE);
    assign slot_live[i] = (slot_q == LIVE);
    assign slot_done[i] = (slot_q == DONE);
  end

  // Outputs trail slot state by one clock; a retire pulse is a DONE slot whose
  // dripStart is still held from the previous cycle, so it lasts exactly one clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drip_start_q     <= '0;
      covid_disapper_q <= '0;
      live_count_q     <= '0;
      all_done_q       <= 1'b0;
    end else begin
      drip_start_q     <= slot_live;
      covid_disapper_q <= drip_start_q & slot_done;
      live_count_q     <= CNT_W'(count_ones8(8'(slot_live)));
      all_done_q       <= &slot_done;
    end
  end

  assign dripStart     = drip_start_q;
  assign covidDisapper = covid_disapper_q;
  assign liveCount     = live_count_q;
  assign allDone       = all_done_q;

endmodule

// File: tb/tb_covid_drop_scheduler.sv
// Directed bench for covid_drop_scheduler: a 2-slot launcher with long lifetime
// and a 2-slot launcher with 5-frame lifetime share frame, pause and reset.
module tb_covid_drop_scheduler;
  import covid_pkg::*;

  logic       clk;
  logic       resetN;
  logic       sof;
  logic       enable;
  logic [1:0] slot_hit;
  logic [1:0] en_mask;
  logic [1:0] drip_en, drip_start, disapper, live_count;
  logic       all_done;
  logic [1:0] l_slot_hit;
  logic [1:0] l_drip_en, l_drip_start, l_disapper, l_live_count;
  logic       l_all_done;

  int n_vec     = 0;
  int n_miscmp  = 0;

  covid_drop_scheduler #(
    .NUM_SLOTS(2), .MIN_GAP_FRAMES(3), .GAP_RANGE_BITS(0),
    .MAX_LIFE_FRAMES(40), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .slotHit(slot_hit), .dripEnable(drip_en), .dripStart(drip_start),
    .covidDisapper(disapper), .liveCount(live_count), .allDone(all_done)
  );

  covid_drop_scheduler #(
    .NUM_SLOTS(2), .MIN_GAP_FRAMES(3), .GAP_RANGE_BITS(0),
    .MAX_LIFE_FRAMES(5), .LFSR_SEED(16'hACE1)
  ) u_life (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .slotHit(l_slot_hit), .dripEnable(l_drip_en), .dripStart(l_drip_start),
    .covidDisapper(l_disapper), .liveCount(l_live_count), .allDone(l_all_done)
  );

  always #5 clk = ~clk;

  // Covid instance stand-in: dripEnable follows dripStart one clock later.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drip_en   <= '0;
      l_drip_en <= '0;
    end else begin
      drip_en   <= drip_start & en_mask;
      l_drip_en <= l_drip_start;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sof_pulse();
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  task automatic frame();
    sof_pulse();
    repeat (4) tick();
  endtask

  initial begin
    clk = 1'b0; resetN = 1'b0; sof = 1'b0; enable = 1'b1;
    slot_hit = '0; l_slot_hit = '0; en_mask = 2'b11;

    #12;
    chk("rst dripStart", 32'(drip_start), 32'h0);
    chk("rst covidDisapper", 32'(disapper), 32'h0);
    chk("rst liveCount", 32'(live_count), 32'h0);
    chk("rst allDone", 32'(all_done), 32'h0);
    chk("rst lfsr", 32'(u_dut.lfsr_w), 32'hACE1);
    @(negedge clk) resetN = 1'b1;
    tick();
    chk("lfsr step", 32'(u_dut.lfsr_w), 32'hE270);

    // Phase A: deterministic launches, lifetime expiry, hits, exhaustion.
    frame(); frame();
    chk("no launch before gap", 32'(drip_start), 32'h0);
    sof_pulse();
    chk("launch e0", 32'(drip_start), 32'h0);
    chk("in pick", 32'(u_dut.sched_q), 32'(PICK));
    tick();
    chk("launch e1", 32'(drip_start), 32'h0);
    tick();
    chk("launch e2", 32'(drip_start), 32'h1);
    chk("live after launch", 32'(live_count), 32'h1);
    chk("life dut launch", 32'(l_drip_start), 32'h1);
    tick(); tick();
    slot_hit = 2'b10; tick(); slot_hit = '0;
    tick(); tick();
    chk("idle hit ignored", 32'(disapper), 32'h0);
    chk("idle hit drip", 32'(drip_start), 32'h1);
    frame(); frame();
    sof_pulse(); tick(); tick();
    chk("second launch", 32'(drip_start), 32'h3);
    chk("live two", 32'(live_count), 32'h2);
    tick(); tick();
    frame();
    sof_pulse();
    chk("timeout e0", 32'(l_disapper), 32'h0);
    tick();
    chk("timeout pulse", 32'(l_disapper), 32'h1);
    chk("timeout drip", 32'(l_drip_start), 32'h2);
    tick();
    chk("timeout pulse end", 32'(l_disapper), 32'h0);
    chk("main unaffected", 32'(drip_start), 32'h3);
    tick(); tick();
    sof_pulse(); tick();
    chk("exhausted", 32'(u_dut.sched_q), 32'(EXHAUSTED));
    chk("exhausted drip", 32'(drip_start), 32'h3);
    chk("exhausted live", 32'(live_count), 32'h2);
    tick(); tick(); tick();
    frame();
    sof_pulse(); tick();
    chk("timeout slot1", 32'(l_disapper), 32'h2);
    chk("life allDone", 32'(l_all_done), 32'h1);
    chk("main not allDone", 32'(all_done), 32'h0);
    tick(); tick(); tick();

    slot_hit = 2'b01; tick(); slot_hit = '0;
    chk("hit e0", 32'(disapper), 32'h0);
    tick();
    chk("hit pulse", 32'(disapper), 32'h1);
    chk("hit drip", 32'(drip_start), 32'h2);
    chk("hit live", 32'(live_count), 32'h1);
    tick();
    chk("hit pulse end", 32'(disapper), 32'h0);

    en_mask = 2'b01; tick(); tick();
    slot_hit = 2'b10; tick(); slot_hit = '0;
    tick(); tick();
    chk("hidden hit ignored", 32'(disapper), 32'h0);
    chk("hidden hit drip", 32'(drip_start), 32'h2);
    chk("hidden hit live", 32'(live_count), 32'h1);
    en_mask = 2'b11; tick(); tick();

    slot_hit = 2'b10; tick(); slot_hit = '0;
    tick();
    chk("hit1 pulse", 32'(disapper), 32'h2);
    chk("hit1 drip", 32'(drip_start), 32'h0);
    chk("hit1 live", 32'(live_count), 32'h0);
    chk("main allDone", 32'(all_done), 32'h1);
    tick();

    // Phase B: async reset while both slots are held.
    @(negedge clk) resetN = 1'b0;
    tick();
    @(negedge clk) resetN = 1'b1;
    frame(); frame(); frame(); frame(); frame();
    sof_pulse(); tick(); tick();
    chk("pre-reset drip", 32'(drip_start), 32'h3);
    #2 resetN = 1'b0;
    #1;
    chk("async drip", 32'(drip_start), 32'h0);
    chk("async disapper", 32'(disapper), 32'h0);
    chk("async live", 32'(live_count), 32'h0);
    chk("async allDone", 32'(all_done), 32'h0);
    chk("async life drip", 32'(l_drip_start), 32'h0);
    tick(); tick();
    @(negedge clk) resetN = 1'b1;

    // Phase C: relaunch after reset, then a 10-frame pause with a hit inside it.
    frame(); frame();
    chk("relaunch not early", 32'(drip_start), 32'h0);
    sof_pulse(); tick(); tick();
    chk("relaunch", 32'(drip_start), 32'h1);
    tick(); tick();
    frame();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        slot_hit = 2'b01; tick(); slot_hit = '0;
        tick();
        chk("pause hit pulse", 32'(disapper), 32'h1);
      end
      frame();
      chk("pause no launch", 32'(drip_start[1]), 32'h0);
    end
    chk("pause hit live", 32'(live_count), 32'h0);
    chk("pause life frozen", 32'(l_drip_start), 32'h1);
    enable = 1'b1;
    frame();
    chk("resume gap", 32'(drip_start), 32'h0);
    sof_pulse(); tick(); tick();
    chk("resume launch", 32'(drip_start), 32'h2);
    chk("resume life dut", 32'(l_drip_start), 32'h3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
